// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default data width and the 2-bit source-unit codes
// that tag every collected result.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef logic [1:0] unit_t;

  localparam unit_t UNIT_ARITH = 2'd0;
  localparam unit_t UNIT_LOGIC = 2'd1;
  localparam unit_t UNIT_CMP   = 2'd2;
  localparam unit_t UNIT_SHIFT = 2'd3;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with an occupancy counter and extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module alu_result_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (cnt_r == DEPTH_C);
  assign empty = (cnt_r == ZERO_C);
  assign rdata = empty ? {DW{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Accept/commit decisions for this edge.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && !empty) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && (!full || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
      cnt_r    <= ZERO_C;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + ONE_C;
        2'b01:   cnt_r <= cnt_r - ONE_C;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects flagged ALU unit results by fixed priority, tags them with their source unit
// and buffers them behind a valid/ready interface; tracks overflow drops and flag conflicts.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Arith_OUT,
  input  logic             Arith_Flag,
  input  logic [WIDTH-1:0] Logic_OUT,
  input  logic             Logic_Flag,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic             CMP_Flag,
  input  logic [WIDTH-1:0] Shift_OUT,
  input  logic             Shift_Flag,
  input  logic             Res_Ready,
  output logic             Res_Valid,
  output logic [WIDTH-1:0] Res_Data,
  output logic [1:0]       Res_Unit,
  output logic             Full,
  output logic             Empty,
  output logic [CNT_W-1:0] Drop_Cnt,
  output logic             Conflict
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic multi_hot(input logic [3:0] f);
    return (f[0] & (f[1] | f[2] | f[3])) | (f[1] & (f[2] | f[3])) | (f[2] & f[3]);
  endfunction

  logic [3:0]       flags_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  unit_t            sel_unit_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [WIDTH+1:0] rdata_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] drop_cnt_r;
  logic             conflict_r;

  assign flags_s = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
  assign push_s  = |flags_s;
  assign pop_s   = !empty_s && Res_Ready;
  assign drop_s  = push_s && full_s && !pop_s;

  // Fixed-priority source selection: Arith > Logic > CMP > Shift.
  always_comb begin
    sel_unit_s = UNIT_ARITH;
    sel_data_s = Arith_OUT;
    if (Arith_Flag) begin
      sel_unit_s = UNIT_ARITH;
      sel_data_s = Arith_OUT;
    end else if (Logic_Flag) begin
      sel_unit_s = UNIT_LOGIC;
      sel_data_s = Logic_OUT;
    end else if (CMP_Flag) begin
      sel_unit_s = UNIT_CMP;
      sel_data_s = CMP_OUT;
    end else begin
      sel_unit_s = UNIT_SHIFT;
      sel_data_s = Shift_OUT;
    end
  end

  alu_result_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({sel_unit_s, sel_data_s}),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Saturating drop counter and sticky conflict flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt_r <= {CNT_W{1'b0}};
      conflict_r <= 1'b0;
    end else begin
      if (drop_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
      if (multi_hot(flags_s)) begin
        conflict_r <= 1'b1;
      end
    end
  end

  assign Res_Valid = !empty_s;
  assign Res_Data  = rdata_s[WIDTH-1:0];
  assign Res_Unit  = rdata_s[WIDTH+1:WIDTH];
  assign Full      = full_s;
  assign Empty     = empty_s;
  assign Drop_Cnt  = drop_cnt_r;
  assign Conflict  = conflict_r;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: a reference queue of expected {unit,data}
// entries is updated as stimulus is driven and compared against the head every cycle.
module tb_alu_result_collector;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [W-1:0]  Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
  logic          Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
  logic          Res_Ready = 1'b0;
  logic          Res_Valid;
  logic [W-1:0]  Res_Data;
  logic [1:0]    Res_Unit;
  logic          Full, Empty;
  logic [CNT_W-1:0] Drop_Cnt;
  logic          Conflict;

  logic [W+1:0]  exp_q[$];
  int            drop_m = 0;
  logic          conf_m = 1'b0;
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  alu_result_collector #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
    .Res_Ready(Res_Ready), .Res_Valid(Res_Valid), .Res_Data(Res_Data), .Res_Unit(Res_Unit),
    .Full(Full), .Empty(Empty), .Drop_Cnt(Drop_Cnt), .Conflict(Conflict)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks outputs at the falling edge, updates the model for the next rising edge, advances.
  task automatic cycle();
    int nf;
    bit popping;
    check("valid", {31'd0, Res_Valid}, {31'd0, exp_q.size() != 0});
    check("empty", {31'd0, Empty}, {31'd0, exp_q.size() == 0});
    check("full", {31'd0, Full}, {31'd0, exp_q.size() == DEPTH});
    check("drop_cnt", 32'(Drop_Cnt), 32'(drop_m));
    check("conflict", {31'd0, Conflict}, {31'd0, conf_m});
    if (exp_q.size() != 0) begin
      check("data", 32'(Res_Data), 32'(exp_q[0][W-1:0]));
      check("unit", 32'(Res_Unit), 32'(exp_q[0][W+1:W]));
    end else begin
      check("data_idle", 32'(Res_Data), 32'd0);
      check("unit_idle", 32'(Res_Unit), 32'd0);
    end
    if (RST) begin
      popping = (exp_q.size() != 0) && Res_Ready;
      if (popping) void'(exp_q.pop_front());
      nf = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(Shift_Flag);
      if (nf >= 2) conf_m = 1'b1;
      if (nf > 0) begin
        if (exp_q.size() < DEPTH) begin
          if (Arith_Flag)      exp_q.push_back({2'd0, Arith_OUT});
          else if (Logic_Flag) exp_q.push_back({2'd1, Logic_OUT});
          else if (CMP_Flag)   exp_q.push_back({2'd2, CMP_OUT});
          else                 exp_q.push_back({2'd3, Shift_OUT});
        end else if (drop_m < 255) begin
          drop_m++;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; Shift_Flag = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    @(negedge CLK);
    // reset held for two cycles, then idle
    cycle();
    cycle();
    RST = 1'b1;
    idle(3);

    // single shift result
    Res_Ready = 1'b1;
    Shift_OUT = 16'h0F0F; Shift_Flag = 1'b1;
    cycle();
    idle(2);

    // priority and conflict
    Arith_OUT = 16'h1234; Arith_Flag = 1'b1;
    Shift_OUT = 16'hFFFF; Shift_Flag = 1'b1;
    cycle();
    idle(3);

    // fill and overflow, then drain
    Res_Ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      Logic_OUT = W'(i); Logic_Flag = 1'b1;
      cycle();
    end
    idle(2);
    Res_Ready = 1'b1;
    idle(5);

    // full with simultaneous pop and push
    Res_Ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      Logic_OUT = W'(16'h0010 + i); Logic_Flag = 1'b1;
      cycle();
    end
    Logic_Flag = 1'b0;
    Res_Ready = 1'b1;
    CMP_OUT = 16'h00AA; CMP_Flag = 1'b1;
    cycle();
    Res_Ready = 1'b0;
    idle(2);
    Res_Ready = 1'b1;
    idle(5);

    // drop counter saturation
    Res_Ready = 1'b0;
    for (int i = 0; i < DEPTH + 300; i++) begin
      Shift_OUT = W'(i); Shift_Flag = 1'b1;
      cycle();
    end
    Res_Ready = 1'b1;
    idle(2);
    Res_Ready = 1'b0;
    idle(1);

    // asynchronous reset mid-cycle with two entries held
    #2;
    RST = 1'b0;
    #1;
    check("rst_valid", {31'd0, Res_Valid}, 32'd0);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_drop", 32'(Drop_Cnt), 32'd0);
    check("rst_conflict", {31'd0, Conflict}, 32'd0);
    exp_q.delete();
    drop_m = 0;
    conf_m = 1'b0;
    @(negedge CLK);
    cycle();
    RST = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the ALU datapath. Consumes the registered outputs and flags of the arithmetic, logic, compare and shift units.
- Tags each valid result with its source-unit code and buffers it in a small FIFO.
- Presents buffered results to the system over a valid/ready handshake, so a stalled consumer does not lose ALU results.

Parameters:
- WIDTH, 16, data width of every unit output and of Res_Data.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- Arith_OUT  in  WIDTH  arithmetic-unit result.
- Arith_Flag  in  1  arithmetic result valid this cycle.
- Logic_OUT  in  WIDTH  logic-unit result.
- Logic_Flag  in  1  logic result valid.
- CMP_OUT  in  WIDTH  compare-unit result.
- CMP_Flag  in  1  compare result valid.
- Shift_OUT  in  WIDTH  shift-unit result.
- Shift_Flag  in  1  shift result valid.
- Res_Ready  in  1  consumer accepts head entry.
- Res_Valid  out  1  head entry available.
- Res_Data  out  WIDTH  head entry data.
- Res_Unit  out  2  head entry source: 0 arith, 1 logic, 2 cmp, 3 shift.
- Full  out  1  FIFO holds DEPTH entries.
- Empty  out  1  FIFO holds 0 entries.
- Drop_Cnt  out  CNT_W  results lost to overflow, saturating.
- Conflict  out  1  sticky: two or more flags were high in the same cycle.

Behaviour:
- Reset (RST low, async): read/write pointers and count go to 0, Empty=1, Full=0, Res_Valid=0, Res_Data=0, Res_Unit=0, Drop_Cnt=0, Conflict=0. Storage contents are don't-care. Reset mid-transfer discards all entries.
- Push request: any of the four flags is high at a rising CLK edge.
- Selection: fixed priority Arith > Logic > CMP > Shift. Only the selected result is pushed.
- Conflict: if two or more flags are high in the same cycle, Conflict is set at that edge and stays set until reset. Lower-priority results in that cycle are not pushed and do not count as drops.
- Pop: Res_Valid && Res_Ready at a rising edge.
- Storage: DEPTH x (WIDTH+2) array. Pointers are log2(DEPTH)+1 bits wide so full and empty are distinguishable. Pointers wrap modulo DEPTH.
- Latency: a result pushed into an empty FIFO at edge N gives Res_Valid=1 after edge N, with Res_Data/Res_Unit from that entry. There is no same-cycle fall-through.
- Outputs: Res_Valid = !Empty. Res_Data and Res_Unit show the head entry while Res_Valid=1 and are 0 while empty. Head must be stable while Res_Valid=1 and Res_Ready=0.
- Full without pop: a push is rejected, storage and pointers are unchanged, and Drop_Cnt increments. Drop_Cnt saturates at 2^CNT_W-1 and never wraps.
- Full with pop in the same cycle: both pop and push happen, the count stays DEPTH, and there is no drop.
- Empty with push in the same cycle: only the push happens. No pop is possible because Res_Valid=0.
- Pop with no push: count decrements; Empty rises when the count reaches 0.
- Full = (count == DEPTH) and Empty = (count == 0), both registered-state derived and glitch-free.
- A flag held high for consecutive cycles pushes one entry per cycle. Each cycle is a new result.

Decomposition:
- Shared package alu_pkg: unit-code constants UNIT_ARITH=2'd0, UNIT_LOGIC=2'd1, UNIT_CMP=2'd2, UNIT_SHIFT=2'd3; ALU width default 16.
- One sub-module, alu_result_fifo: a generic synchronous FIFO (WIDTH+2 data, DEPTH) with push/pop, full/empty and async active-low reset.
- The top level contains the priority selector, Conflict flag and Drop_Cnt logic.

Test Plan:
- Reset then idle: RST low for 2 cycles -> Res_Valid=0, Empty=1, Full=0, Drop_Cnt=0, Conflict=0; all remain so with all flags low.
- Single shift result: Shift_OUT=16'h0F0F, Shift_Flag=1 for one cycle, Res_Ready=1 -> next cycle Res_Valid=1, Res_Data=16'h0F0F, Res_Unit=3; the cycle after that Empty=1.
- Priority and conflict: Arith_Flag=1 (16'h1234) and Shift_Flag=1 (16'hFFFF) in the same cycle -> one entry with Res_Data=16'h1234, Res_Unit=0; Conflict=1 and stays 1; Drop_Cnt=0.
- Fill and overflow: Res_Ready=0, Logic_Flag=1 for 6 cycles with data 1..6 -> Full after the 4th push, Drop_Cnt=2; then Res_Ready=1 drains 1,2,3,4 in order with Res_Unit=1.
- Full plus simultaneous pop/push: FIFO full, Res_Ready=1 and CMP_Flag=1 (16'h00AA) -> count stays 4, Full stays 1, Drop_Cnt unchanged, 16'h00AA appears as the 4th entry behind the three remaining ones.
- Saturation and async reset: with CNT_W=8, force 300 drops -> Drop_Cnt=255; assert RST mid-cycle with 2 entries held -> immediately Res_Valid=0, Drop_Cnt=0, Conflict=0.
